rca_share_arb: RTL and testbench
================================

Name: rca_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit ripple-carry adder (9-bit sum output) between NUM_REQ requesters.
- Per request, it accepts an operand pair over a valid/ready handshake and drives the registered operands into the external adder.
- It waits SETTLE_CYCLES so the ripple chain settles (multicycle path), then captures the 9-bit sum and returns it with the requester ID on a single valid/ready response port.
- It sits between client blocks and the adder instance in the datapath top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- SETTLE_CYCLES, 1, cycles the adder inputs are held stable before the sum is sampled (1..15).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NUM_REQ  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational.
- add_a  output  8  registered operand A to the adder.
- add_b  output  8  registered operand B to the adder.
- add_sum  input  9  adder result; bit 8 is the carry out.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_sum  output  9  captured sum.
- rsp_id  output  ID_W  index of the requester served.
- busy  output  1  high whenever state != IDLE.
- op_count  output  16  completed responses, wraps from 0xFFFF to 0.

Behaviour:
- Reset (async assert, sync use after deassert):
  - state=IDLE.
  - add_a=0, add_b=0, rsp_valid=0, rsp_sum=0, rsp_id=0, busy=0, op_count=0.
  - Round-robin pointer ptr=0.
- Reset mid-operation: the in-flight request is discarded and no response is issued. The requester sees no completion and re-requests.
- State IDLE:
  - Grant g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NUM_REQ.
  - req_ready[g]=1 only in IDLE and only when req_valid[g]=1; otherwise req_ready=0.
  - On the accept edge:
    - add_a<=req_a[g], add_b<=req_b[g], rsp_id<=g.
    - ptr<=(g+1) mod NUM_REQ.
    - cnt<=0, state<=SETTLE.
  - With no valid request, stay in IDLE and leave ptr unchanged.
- State SETTLE:
  - add_a/add_b held constant.
  - cnt increments each cycle.
  - On the edge where cnt==SETTLE_CYCLES-1: rsp_sum<=add_sum, rsp_valid<=1, state<=RESP.
- State RESP:
  - rsp_valid, rsp_sum and rsp_id are held stable until rsp_ready=1.
  - On the handshake edge: rsp_valid<=0, op_count<=op_count+1, state<=IDLE.
- Latency and throughput:
  - rsp_valid rises exactly SETTLE_CYCLES cycles after the accept edge.
  - With rsp_ready tied high, one accept every SETTLE_CYCLES+2 cycles; there is no overlap between requests.
- add_a/add_b keep their last values between requests; they are not cleared.
- Requesters must hold req_valid and operands stable until req_ready is seen. Dropping req_valid early is legal; that requester is simply not granted.
- Simultaneous requests: round robin guarantees each waiting requester is served within NUM_REQ grants.
- Arithmetic: the block does not add. rsp_sum is exactly add_sum as sampled, so 0xFF+0xFF gives 0x1FE.
- Illegal parameters (SETTLE_CYCLES=0, 2**ID_W<NUM_REQ) are caught by an elaboration-time check.

Test Plan:
- Reset, then requester 0 sends A=0x0F, B=0x01 with SETTLE_CYCLES=1 and rsp_ready=1:
  - req_ready[0] is high for 1 cycle.
  - add_a=0x0F, add_b=0x01.
  - rsp_valid is high 1 cycle after accept with rsp_sum=0x010, rsp_id=0.
  - op_count=1.
- All 4 requesters hold req_valid continuously with distinct operands:
  - Grant order is 0,1,2,3,0.
  - Each rsp_id matches its operands, e.g. req 2 with A=0xFF, B=0xFF gives rsp_sum=0x1FE.
- SETTLE_CYCLES=3, A=0x80, B=0x80:
  - rsp_valid rises 3 cycles after accept with rsp_sum=0x100.
  - add_a/add_b stay constant throughout SETTLE.
- Backpressure: rsp_ready=0 for 5 cycles in RESP:
  - rsp_valid, rsp_sum and rsp_id are stable; busy=1.
  - All req_ready=0 even with requests pending.
  - Releasing rsp_ready returns the block to IDLE, and the next grant follows in the following cycle.
- Assert rst during SETTLE:
  - All outputs go to their reset values immediately; no response is issued.
  - ptr=0, so after reset with req 1 and req 3 pending, req 1 is granted first.
- op_count wrap: preload 0xFFFF completions via a fast bench loop; one more response makes op_count=0x0000.

Source files
------------

// File: rtl/rca_share_arb_if.sv
// Bundle between client blocks, the shared ripple-carry adder
// and the arbiter: request side, adder side and response side.
interface rca_share_arb_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           add_a;
   logic [7:0]           add_b;
   logic [8:0]           add_sum;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [8:0]           rsp_sum;
   logic [ID_W-1:0]      rsp_id;
   logic                 busy;
   logic [15:0]          op_count;

   modport master (
      output req_valid, req_a, req_b,
      output add_sum, rsp_ready,
      input  req_ready, add_a, add_b,
      input  rsp_valid, rsp_sum, rsp_id,
      input  busy, op_count
   );

   modport slave (
      input  req_valid, req_a, req_b,
      input  add_sum, rsp_ready,
      output req_ready, add_a, add_b,
      output rsp_valid, rsp_sum, rsp_id,
      output busy, op_count
   );
endinterface

// File: rtl/rca_share_arb.sv
// Round-robin arbiter sharing one external 8-bit ripple-carry adder;
// operands are held for SETTLE_CYCLES before the sum is captured.
module rca_share_arb #(
   parameter int NUM_REQ       = 4,
   parameter int ID_W          = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input logic            clk,
   input logic            rst,
   rca_share_arb_if.slave bus
);
   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 ||
          SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15 ||
          (2**ID_W) < NUM_REQ) begin : g_bad_param
         $error("rca_share_arb: illegal parameters");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      RESP
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [ID_W-1:0] r_ptr;
   logic [3:0]      r_cnt;
   logic [7:0]      r_add_a;
   logic [7:0]      r_add_b;
   logic            r_rsp_valid;
   logic [8:0]      r_rsp_sum;
   logic [ID_W-1:0] r_rsp_id;
   logic [15:0]     r_op_count;

   logic               w_any;
   logic [ID_W-1:0]    w_gnt;
   logic [ID_W-1:0]    w_ptr_nxt;
   logic [NUM_REQ-1:0] w_ready;
   logic               w_accept;
   logic               w_settle_done;
   logic               w_rsp_fire;
   int                 v_dist;
   int                 v_best;

   // Winner is the valid requester closest to r_ptr going upward.
   always_comb begin
      w_any  = 1'b0;
      w_gnt  = '0;
      v_best = NUM_REQ;
      v_dist = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         v_dist = i - int'(r_ptr);
         if (v_dist < 0) v_dist = v_dist + NUM_REQ;
         if (bus.req_valid[i] && v_dist < v_best) begin
            v_best = v_dist;
            w_gnt  = ID_W'(i);
            w_any  = 1'b1;
         end
      end
   end

   always_comb begin
      w_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_ready[i] = (r_state == IDLE) && w_any &&
                      (w_gnt == ID_W'(i));
      end
   end

   assign w_ptr_nxt = (w_gnt == ID_W'(NUM_REQ - 1)) ?
                      '0 : w_gnt + ID_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = 1'b0;
      w_settle_done = 1'b0;
      w_rsp_fire    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_any) begin
               w_accept    = 1'b1;
               w_state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            if (r_cnt == 4'(SETTLE_CYCLES - 1)) begin
               w_settle_done = 1'b1;
               w_state_nxt   = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               w_rsp_fire  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_sum   <= '0;
         r_rsp_id    <= '0;
         r_op_count  <= '0;
      end else begin
         if (w_accept) begin
            r_add_a  <= bus.req_a[8*w_gnt +: 8];
            r_add_b  <= bus.req_b[8*w_gnt +: 8];
            r_rsp_id <= w_gnt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= '0;
         end
         if (r_state == SETTLE) r_cnt <= r_cnt + 4'd1;
         // Multicycle capture: adder inputs have been stable long enough.
         if (w_settle_done) begin
            r_rsp_sum   <= bus.add_sum;
            r_rsp_valid <= 1'b1;
         end
         if (w_rsp_fire) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.add_a     = r_add_a;
   assign bus.add_b     = r_add_b;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_sum   = r_rsp_sum;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.busy      = (r_state != IDLE);
   assign bus.op_count  = r_op_count;
endmodule

// File: tb/tb_rca_share_arb.sv
// Bench for rca_share_arb: two instances (settle 1 and 3), cycle
// reference model of arbitration plus a response scoreboard.
module tb_rca_share_arb;
   localparam int N  = 4;
   localparam int IW = 2;

   typedef logic [10:0] rsp_t;

   logic clk;
   logic rst;

   rca_share_arb_if #(.NUM_REQ(N), .ID_W(IW)) bus0 ();
   rca_share_arb_if #(.NUM_REQ(N), .ID_W(IW)) bus1 ();

   rca_share_arb #(
      .NUM_REQ(N), .ID_W(IW), .SETTLE_CYCLES(1)
   ) u_dut0 (
      .clk(clk), .rst(rst), .bus(bus0.slave)
   );

   rca_share_arb #(
      .NUM_REQ(N), .ID_W(IW), .SETTLE_CYCLES(3)
   ) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave)
   );

   logic [N-1:0]   t_valid [2];
   logic [8*N-1:0] t_a     [2];
   logic [8*N-1:0] t_b     [2];
   logic           t_rrdy  [2];

   assign bus0.req_valid = t_valid[0];
   assign bus0.req_a     = t_a[0];
   assign bus0.req_b     = t_b[0];
   assign bus0.rsp_ready = t_rrdy[0];
   assign bus1.req_valid = t_valid[1];
   assign bus1.req_a     = t_a[1];
   assign bus1.req_b     = t_b[1];
   assign bus1.rsp_ready = t_rrdy[1];

   // External adders.
   assign bus0.add_sum = {1'b0, bus0.add_a} + {1'b0, bus0.add_b};
   assign bus1.add_sum = {1'b0, bus1.add_a} + {1'b0, bus1.add_b};

   wire [N-1:0]  o_rdy  [2];
   wire [7:0]    o_aa   [2];
   wire [7:0]    o_ab   [2];
   wire          o_rv   [2];
   wire [8:0]    o_sum  [2];
   wire [IW-1:0] o_id   [2];
   wire          o_busy [2];
   wire [15:0]   o_cnt  [2];

   assign o_rdy[0]  = bus0.req_ready;
   assign o_aa[0]   = bus0.add_a;
   assign o_ab[0]   = bus0.add_b;
   assign o_rv[0]   = bus0.rsp_valid;
   assign o_sum[0]  = bus0.rsp_sum;
   assign o_id[0]   = bus0.rsp_id;
   assign o_busy[0] = bus0.busy;
   assign o_cnt[0]  = bus0.op_count;
   assign o_rdy[1]  = bus1.req_ready;
   assign o_aa[1]   = bus1.add_a;
   assign o_ab[1]   = bus1.add_b;
   assign o_rv[1]   = bus1.rsp_valid;
   assign o_sum[1]  = bus1.rsp_sum;
   assign o_id[1]   = bus1.rsp_id;
   assign o_busy[1] = bus1.busy;
   assign o_cnt[1]  = bus1.op_count;

   // Reference model state, per instance.
   int          m_ptr  [2];
   int          m_left [2];
   bit          m_idle [2];
   bit          m_wait [2];
   logic [15:0] m_cnt  [2];
   logic [7:0]  m_a    [2];
   logic [7:0]  m_b    [2];
   int          m_mode [2];   // 0 drop after grant, 1 hold, 2 random
   rsp_t        q0[$];
   rsp_t        q1[$];

   int n_chk = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int settle(input int s);
      return (s == 0) ? 1 : 3;
   endfunction

   function automatic int grant(input int s);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = (m_ptr[s] + k) % N;
         if (t_valid[s][idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_ptr[s]  = 0;
         m_left[s] = 0;
         m_idle[s] = 1'b1;
         m_wait[s] = 1'b0;
         m_cnt[s]  = '0;
         m_a[s]    = '0;
         m_b[s]    = '0;
      end
      q0.delete();
      q1.delete();
   endtask

   // One clock: check both instances, advance the model, move requesters.
   task automatic cyc();
      int          g;
      int          acc [2];
      logic [N-1:0] er;
      rsp_t        e;
      #1;
      for (int s = 0; s < 2; s++) begin
         g  = grant(s);
         er = '0;
         if (m_idle[s] && g >= 0) er[g] = 1'b1;
         chk($sformatf("req_ready%0d", s), 32'(o_rdy[s]), 32'(er));
         chk($sformatf("busy%0d", s), 32'(o_busy[s]),
             32'(!m_idle[s]));
         chk($sformatf("rsp_valid%0d", s), 32'(o_rv[s]),
             32'(m_wait[s]));
         chk($sformatf("op_count%0d", s), 32'(o_cnt[s]),
             32'(m_cnt[s]));
         chk($sformatf("add_a%0d", s), 32'(o_aa[s]), 32'(m_a[s]));
         chk($sformatf("add_b%0d", s), 32'(o_ab[s]), 32'(m_b[s]));
         acc[s] = -1;
         if (m_idle[s]) begin
            if (g >= 0) begin
               m_a[s]    = t_a[s][8*g +: 8];
               m_b[s]    = t_b[s][8*g +: 8];
               e = {2'(g), 9'(m_a[s]) + 9'(m_b[s])};
               if (s == 0) q0.push_back(e);
               else        q1.push_back(e);
               m_ptr[s]  = (g + 1) % N;
               m_idle[s] = 1'b0;
               m_left[s] = settle(s);
               acc[s]    = g;
            end
         end else if (!m_wait[s]) begin
            m_left[s]--;
            if (m_left[s] == 0) m_wait[s] = 1'b1;
         end else if (t_rrdy[s]) begin
            m_wait[s] = 1'b0;
            m_idle[s] = 1'b1;
            m_cnt[s]  = m_cnt[s] + 16'd1;
         end
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         if (acc[s] >= 0 && m_mode[s] == 0)
            t_valid[s][acc[s]] = 1'b0;
         if (m_mode[s] == 2) begin
            if (acc[s] >= 0) begin
               t_valid[s][acc[s]] = 1'($urandom % 2);
               t_a[s][8*acc[s] +: 8] = 8'($urandom);
               t_b[s][8*acc[s] +: 8] = 8'($urandom);
            end
            for (int i = 0; i < N; i++) begin
               if (!t_valid[s][i] && ($urandom % 3) == 0) begin
                  t_valid[s][i] = 1'b1;
                  t_a[s][8*i +: 8] = 8'($urandom);
                  t_b[s][8*i +: 8] = 8'($urandom);
               end
            end
            t_rrdy[s] = ($urandom % 10) < 7;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   // Called at a falling edge; pulses reset and checks reset values.
   task automatic do_reset(input logic [N-1:0] v1_after);
      rst = 1'b1;
      t_valid[0] = '0;
      t_valid[1] = '0;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("rst_add_a%0d", s), 32'(o_aa[s]), 0);
         chk($sformatf("rst_add_b%0d", s), 32'(o_ab[s]), 0);
         chk($sformatf("rst_rsp_valid%0d", s), 32'(o_rv[s]), 0);
         chk($sformatf("rst_rsp_sum%0d", s), 32'(o_sum[s]), 0);
         chk($sformatf("rst_rsp_id%0d", s), 32'(o_id[s]), 0);
         chk($sformatf("rst_busy%0d", s), 32'(o_busy[s]), 0);
         chk($sformatf("rst_op_count%0d", s), 32'(o_cnt[s]), 0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      t_valid[1] = v1_after;
   endtask

   // Scoreboard monitor: response content checked while valid is shown.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (o_rv[0]) begin
            if (q0.size() == 0) begin
               chk("rsp0_unexpected", 32'(o_rv[0]), 0);
            end else begin
               chk("rsp0", 32'({o_id[0], o_sum[0]}), 32'(q0[0]));
               if (t_rrdy[0]) void'(q0.pop_front());
            end
         end
         if (o_rv[1]) begin
            if (q1.size() == 0) begin
               chk("rsp1_unexpected", 32'(o_rv[1]), 0);
            end else begin
               chk("rsp1", 32'({o_id[1], o_sum[1]}), 32'(q1[0]));
               if (t_rrdy[1]) void'(q1.pop_front());
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         t_valid[s] = '0;
         t_a[s]     = '0;
         t_b[s]     = '0;
         t_rrdy[s]  = 1'b1;
         m_mode[s]  = 0;
      end
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Single request on instance 0: 0x0F + 0x01.
      t_a[0][7:0] = 8'h0F;
      t_b[0][7:0] = 8'h01;
      t_valid[0]  = 4'b0001;
      run(6);

      // All four held continuously, from a fresh pointer.
      do_reset('0);
      t_a[0] = {8'h00, 8'hFF, 8'h7F, 8'h11};
      t_b[0] = {8'h00, 8'hFF, 8'h01, 8'h22};
      t_valid[0] = 4'hF;
      m_mode[0] = 1;
      run(15);
      t_valid[0] = '0;
      m_mode[0] = 0;
      run(4);

      // Settle of 3 cycles: 0x80 + 0x80.
      t_a[1][7:0] = 8'h80;
      t_b[1][7:0] = 8'h80;
      t_valid[1]  = 4'b0001;
      run(8);

      // Response backpressure with requests pending.
      t_a[1] = {8'h00, 8'h33, 8'h44, 8'h00};
      t_b[1] = {8'h00, 8'h05, 8'h06, 8'h00};
      t_rrdy[1]  = 1'b0;
      t_valid[1] = 4'b0110;
      run(9);
      t_rrdy[1] = 1'b1;
      run(12);

      // Reset while instance 1 is settling.
      t_a[1] = {8'h31, 8'h00, 8'h21, 8'h12};
      t_b[1] = {8'h03, 8'h00, 8'h02, 8'h34};
      t_valid[1] = 4'b0001;
      run(2);
      do_reset(4'b1010);
      run(14);

      // Counter wrap on instance 0.
      force u_dut0.r_op_count = 16'hFFFE;
      #1;
      release u_dut0.r_op_count;
      m_cnt[0] = 16'hFFFE;
      t_a[0][31:24] = 8'h01;
      t_b[0][31:24] = 8'h02;
      t_valid[0] = 4'b1000;
      m_mode[0] = 1;
      run(6);
      t_valid[0] = '0;
      m_mode[0] = 0;
      run(4);

      // Random traffic on both instances.
      m_mode[0] = 2;
      m_mode[1] = 2;
      run(400);
      m_mode[0] = 0;
      m_mode[1] = 0;
      t_valid[0] = '0;
      t_valid[1] = '0;
      t_rrdy[0]  = 1'b1;
      t_rrdy[1]  = 1'b1;
      run(12);
      chk("q0_drained", 32'(q0.size()), 0);
      chk("q1_drained", 32'(q1.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
